// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline stages and their control logic.
// Holds the icode, stat and register-ID constants, the run-state enum
// used by the pipeline controller, and the exc() status classifier.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        RUN,
        HALTED
    } runState_t;

    // Any status other than HLT/ADR/INS (including out-of-range codes)
    // behaves as AOK.
    function automatic logic exc(input logic [3:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Pure-combinational hazard detector for the five-stage pipe.
// Ports:
//   D_icode, E_icode, M_icode : icodes in decode/execute/memory registers
//   E_dstM                    : execute-stage load destination (RNONE = none)
//   d_srcA, d_srcB            : decode-stage source register IDs
//   e_Cnd                     : branch condition evaluated in execute
//   loadUse                   : load in E feeds a source read in D
//   mispred                   : conditional jump in E was not taken
//   retPend                   : a RET is in D, E or M
module pipe_hazard
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       e_Cnd,
    output logic       loadUse,
    output logic       mispred,
    output logic       retPend
);

    always_comb begin
        loadUse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred = (E_icode == I_JXX) && !e_Cnd;
        retPend = (D_icode == I_RET) || (E_icode == I_RET) ||
                  (M_icode == I_RET);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 core.
// Computes per-cycle stall/bubble controls and the CC write enable,
// freezes the pipe once an exception retires, and keeps saturating
// performance counters.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   D/E/M/W_icode                    : icodes in the stage registers
//   E_dstM, d_srcA, d_srcB, e_Cnd    : hazard-detection inputs
//   m_stat, W_stat                   : memory-stage and writeback status
//   F_stall, D_stall, W_stall        : hold the named stage register
//   D_bubble, E_bubble, M_bubble     : load NOP/AOK into the named register
//   set_cc                           : condition-code write enable
//   halted, cpu_stat                 : frozen flag and latched final status
//   cyc_cnt, ret_cnt, stall_cnt, bub_cnt : saturating counters
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    runState_t state, stateNext;
    logic      loadUse, mispred, retPend;
    logic      mExc, wExc;
    logic [1:0]       bubInc;
    logic [CNT_W-1:0] bubIncW;

    pipe_hazard uHazard (
        .D_icode (D_icode),
        .E_icode (E_icode),
        .M_icode (M_icode),
        .E_dstM  (E_dstM),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .e_Cnd   (e_Cnd),
        .loadUse (loadUse),
        .mispred (mispred),
        .retPend (retPend)
    );

    assign mExc = exc(m_stat);
    assign wExc = exc(W_stat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cpu_stat <= S_AOK;
        end else begin
            state <= stateNext;
            if (state == RUN && wExc)
                cpu_stat <= W_stat;
        end
    end

    // The frozen override is suppressed while rst is high so the reset
    // cycle already sees the RUN equations.
    always_comb begin
        stateNext = state;
        F_stall   = loadUse || retPend;
        D_stall   = loadUse;
        D_bubble  = mispred || (retPend && !loadUse);
        E_bubble  = mispred || loadUse;
        M_bubble  = mExc || wExc;
        W_stall   = wExc;
        set_cc    = (E_icode == I_OPQ) && !mExc && !wExc;
        case (state)
            RUN: begin
                if (wExc)
                    stateNext = HALTED;
            end
            HALTED: begin
                if (!rst) begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    D_bubble = 1'b0;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    set_cc   = 1'b0;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    assign halted  = (state == HALTED);
    assign bubInc  = {1'b0, D_bubble} + {1'b0, E_bubble} + {1'b0, M_bubble};
    assign bubIncW = {{(CNT_W-2){1'b0}}, bubInc};

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            bub_cnt   <= '0;
        end else if (state == RUN) begin
            if (cyc_cnt != CNT_MAX)
                cyc_cnt <= cyc_cnt + CNT_ONE;
            if (W_stat == S_AOK && W_icode != I_NOP && !W_stall &&
                ret_cnt != CNT_MAX)
                ret_cnt <= ret_cnt + CNT_ONE;
            if (F_stall && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            // Multi-step increment: clamp when the headroom is smaller.
            if (bub_cnt > CNT_MAX - bubIncW)
                bub_cnt <= CNT_MAX;
            else
                bub_cnt <= bub_cnt + bubIncW;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, E_icode, M_icode, W_icode;
    logic [3:0] E_dstM, d_srcA, d_srcB;
    logic       e_Cnd;
    logic [3:0] m_stat, W_stat;

    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
    logic        set_cc, halted;
    logic [3:0]  cpu_stat;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;

    logic        sF_stall, sD_stall, sW_stall, sD_bubble, sE_bubble, sM_bubble;
    logic        sSet_cc, sHalted;
    logic [3:0]  sCpu_stat;
    logic [3:0]  sCyc_cnt, sRet_cnt, sStall_cnt, sBub_cnt;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl uDut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .halted(halted), .cpu_stat(cpu_stat),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) uSmall (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(sF_stall), .D_stall(sD_stall), .W_stall(sW_stall),
        .D_bubble(sD_bubble), .E_bubble(sE_bubble), .M_bubble(sM_bubble),
        .set_cc(sSet_cc), .halted(sHalted), .cpu_stat(sCpu_stat),
        .cyc_cnt(sCyc_cnt), .ret_cnt(sRet_cnt), .stall_cnt(sStall_cnt), .bub_cnt(sBub_cnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic setIdle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b0;
        m_stat = 4'h1; W_stat = 4'h1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the six stall/bubble controls as {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble}.
    function automatic logic [31:0] ctl();
        return {26'd0, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        setIdle();
        tick();
        rst = 1'b0;
    endtask

    task automatic checkCnt(input string tag, input int unsigned c, input int unsigned r,
                            input int unsigned s, input int unsigned b);
        checkVal({tag, "_cyc"}, cyc_cnt, c);
        checkVal({tag, "_ret"}, ret_cnt, r);
        checkVal({tag, "_stall"}, stall_cnt, s);
        checkVal({tag, "_bub"}, bub_cnt, b);
    endtask

    initial begin
        setIdle();
        rst = 1'b1;
        tick();
        doReset();

        // Reset state and idle controls
        checkVal("rst_halted", halted, 0);
        checkVal("rst_cpu_stat", cpu_stat, 4'h1);
        checkCnt("rst", 0, 0, 0, 0);
        #1;
        checkVal("idle_ctl", ctl(), 6'b000000);
        checkVal("idle_set_cc", set_cc, 0);

        // Saturation: 20 hazard-free cycles
        for (int i = 0; i < 20; i++) tick();
        checkVal("sat_big_cyc", cyc_cnt, 20);
        checkVal("sat_small_cyc", sCyc_cnt, 4'hF);
        checkVal("sat_small_stall", sStall_cnt, 0);

        // Load-use via srcA, RNONE boundary, POPQ via srcB
        doReset();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h6;
        #1;
        checkVal("lu_ctl", ctl(), 6'b110010);
        tick();
        setIdle();
        E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        #1;
        checkVal("lu_rnone_ctl", ctl(), 6'b000000);
        tick();
        setIdle();
        E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        #1;
        checkVal("lu_popq_ctl", ctl(), 6'b110010);
        tick();
        setIdle();
        checkCnt("lu", 3, 1, 2, 2);

        // Mispredict
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        checkVal("mp_ctl", ctl(), 6'b000110);
        e_Cnd = 1'b1;
        #1;
        checkVal("taken_ctl", ctl(), 6'b000000);

        // RET walking D -> E -> M, then gone; then RET with load-use
        doReset();
        D_icode = 4'h9;
        #1; checkVal("ret_d_ctl", ctl(), 6'b100100);
        tick();
        D_icode = 4'h1; E_icode = 4'h9;
        #1; checkVal("ret_e_ctl", ctl(), 6'b100100);
        tick();
        E_icode = 4'h1; M_icode = 4'h9;
        #1; checkVal("ret_m_ctl", ctl(), 6'b100100);
        tick();
        M_icode = 4'h1;
        #1; checkVal("ret_gone_ctl", ctl(), 6'b000000);
        tick();
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
        #1; checkVal("ret_lu_ctl", ctl(), 6'b110010);
        tick();
        setIdle();
        checkCnt("ret", 5, 0, 4, 4);

        // Exception in memory, then retiring
        doReset();
        E_icode = 4'h6;
        #1; checkVal("cc_ok", set_cc, 1);
        tick();
        m_stat = 4'h3;
        #1;
        checkVal("mexc_cc", set_cc, 0);
        checkVal("mexc_ctl", ctl(), 6'b000001);
        tick();
        setIdle();
        W_stat = 4'h3;
        #1;
        checkVal("wexc_ctl", ctl(), 6'b001001);
        checkVal("wexc_halted_pre", halted, 0);
        tick();
        checkVal("wexc_halted", halted, 1);
        checkVal("wexc_cpu_stat", cpu_stat, 4'h3);
        setIdle();
        E_icode = 4'h6; D_icode = 4'h9;
        #1;
        checkVal("halt_ctl", ctl(), 6'b111011);
        checkVal("halt_cc", set_cc, 0);
        for (int i = 0; i < 3; i++) tick();
        checkVal("halt_stay", halted, 1);
        checkCnt("halt", 3, 0, 0, 2);

        // rst in HALTED: RUN equations during the reset cycle
        setIdle();
        rst = 1'b1;
        #1;
        checkVal("rstcyc_ctl", ctl(), 6'b000000);
        tick();
        rst = 1'b0;
        checkVal("rst2_halted", halted, 0);
        checkVal("rst2_cpu_stat", cpu_stat, 4'h1);
        checkCnt("rst2", 0, 0, 0, 0);

        // Out-of-range W_stat behaves as AOK, then HALT retire
        W_stat = 4'h0;
        #1; checkVal("wbad_wstall", W_stall, 0);
        tick();
        checkVal("wbad_halted", halted, 0);
        W_icode = 4'h0; W_stat = 4'h2;
        tick();
        checkVal("hlt_halted", halted, 1);
        checkVal("hlt_cpu_stat", cpu_stat, 4'h2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
